matrix_result_serializer: RTL

//  Drains packed matrix words produced by the matrix arithmetic stage and emits

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_elem_select.sv | 34 +++
 rtl/matrix_result_serializer.sv | 95 +++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared matrix geometry, packing rule and serializer state encoding.
// Element (r,c) of a packed word sits at MSB-first position r*N+c.
package matrix_pkg;

  localparam int ELEM_WIDTH  = 16;
  localparam int MATRIX_SIZE = 2;
  localparam int NUM_ELEMS   = MATRIX_SIZE * MATRIX_SIZE;
  localparam int DATA_WIDTH  = NUM_ELEMS * ELEM_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  function automatic logic [ELEM_WIDTH-1:0] elem_slice(
    input logic [DATA_WIDTH-1:0] word,
    input int unsigned           r,
    input int unsigned           c
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = word << ((r * MATRIX_SIZE + c) * ELEM_WIDTH);
    return sh[DATA_WIDTH-1 -: ELEM_WIDTH];
  endfunction

endpackage

// File: rtl/matrix_elem_select.sv
// Combinational pick of the k-th element of a packed matrix word,
// walking either row-major or column-major.
module matrix_elem_select #(
  parameter int ELEM_WIDTH  = 16,
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int IDX_WIDTH   = 2
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [IDX_WIDTH-1:0]  k,
  input  logic                  col_major,
  output logic [ELEM_WIDTH-1:0] elem
);

  int unsigned           kk;
  int unsigned           r;
  int unsigned           c;
  logic [DATA_WIDTH-1:0] sh;

  always_comb begin
    kk = 32'(k);
    if (col_major) begin
      r = kk % MATRIX_SIZE;
      c = kk / MATRIX_SIZE;
    end else begin
      r = kk / MATRIX_SIZE;
      c = kk % MATRIX_SIZE;
    end
    // Shift the wanted element up to the MSBs, then take the top slice.
    sh   = word << ((r * MATRIX_SIZE + c) * ELEM_WIDTH);
    elem = sh[DATA_WIDTH-1 -: ELEM_WIDTH];
  end

endmodule

// File: rtl/matrix_result_serializer.sv
// Drains packed matrix words and emits one element per cycle over valid/ready.
//   state | meaning
//   IDLE  | no word held, ready for the next packed word
//   SEND  | emitting elements of the held word, idx = next sequence index
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int ELEM_WIDTH  = matrix_pkg::ELEM_WIDTH,
  parameter int MATRIX_SIZE = matrix_pkg::MATRIX_SIZE,
  parameter int DATA_WIDTH  = matrix_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  col_major,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [15:0]           word_count
);

  localparam int N_ELEMS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W   = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

  if (DATA_WIDTH != N_ELEMS * ELEM_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must equal MATRIX_SIZE*MATRIX_SIZE*ELEM_WIDTH");
  end

  ser_state_e            state;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] hold_word;
  logic                  hold_col_major;
  logic [15:0]           word_count_q;

  // Outputs depend only on registered state; in_ready alone sees out_ready.
  assign out_valid  = (state == SEND);
  assign out_last   = (state == SEND) && (idx == LAST_IDX);
  assign in_ready   = (state == IDLE) || (out_ready && out_last);
  assign word_count = word_count_q;

  matrix_elem_select #(
    .ELEM_WIDTH  (ELEM_WIDTH),
    .MATRIX_SIZE (MATRIX_SIZE),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_WIDTH   (IDX_W)
  ) u_elem_select (
    .word      (hold_word),
    .k         (idx),
    .col_major (hold_col_major),
    .elem      (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      hold_word      <= '0;
      hold_col_major <= 1'b0;
      word_count_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold_word      <= in_data;
            hold_col_major <= col_major;
            idx            <= '0;
            state          <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              word_count_q <= word_count_q + 16'd1;
              idx          <= '0;
              if (in_valid) begin
                hold_word      <= in_data;
                hold_col_major <= col_major;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
